conv2_tiled_engine: RTL and testbench

- Parametrised successor to the fixed 4x4-tile conv2 layer block.
- Computes a valid-mode 2-D convolution of a SIZE x SIZE signed fixed-point image with a runtime-loadable KxK kernel.
- Adds stride, bias, fixed-point rescale with saturation, optional ReLU, and a start/busy/done handshake.
- Output plane is split into TILES x TILES regions, each served by one sequential MAC lane. Sits between the image buffer and the pooling stage of the CNN datapath.

---
 rtl/conv2_tiled_engine_if.sv | 27 ++
 rtl/conv2_tiled_engine.sv | 187 ++++++++++++++++++
 tb/tb_conv2_tiled_engine.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/conv2_tiled_engine_if.sv
// Handshake and data bus of conv2_tiled_engine: the image buffer side drives the
// master modport, and the engine takes the slave modport.
interface conv2_tiled_engine_if #(
  parameter int SIZE      = 8,
  parameter int SIZEKer   = 3,
  parameter int WIDTH_BIT = 16,
  parameter int OUT       = 6
);
  logic                        start;
  logic                        relu_en;
  logic signed [WIDTH_BIT-1:0] bias;
  logic signed [WIDTH_BIT-1:0] kernel          [SIZEKer][SIZEKer];
  logic signed [WIDTH_BIT-1:0] inpMatrixI      [SIZE][SIZE];
  logic                        busy;
  logic                        done;
  logic signed [WIDTH_BIT-1:0] convIxKernelOut [OUT][OUT];

  modport master (
    output start, relu_en, bias, kernel, inpMatrixI,
    input  busy, done, convIxKernelOut
  );

  modport slave (
    input  start, relu_en, bias, kernel, inpMatrixI,
    output busy, done, convIxKernelOut
  );
endinterface

// File: rtl/conv2_tiled_engine.sv
// Tiled valid-mode 2-D convolution engine. TILES x TILES sequential MAC lanes
// each walk their own TSZ x TSZ region of the output plane, one window per pass.
module conv2_tiled_engine #(
  parameter int SIZE      = 8,
  parameter int SIZEKer   = 3,
  parameter int STRIDE    = 1,
  parameter int TILES     = 2,
  parameter int WIDTH_BIT = 16,
  parameter int FRAC      = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  conv2_tiled_engine_if.slave   bus
);
  localparam int K     = SIZEKer;
  localparam int KK    = K * K;
  localparam int W     = WIDTH_BIT;
  localparam int OUT   = (SIZE - K) / STRIDE + 1;
  localparam int TSZ   = OUT / TILES;
  localparam int ACC_W = 2 * W + $clog2(KK) + 1;
  localparam int KW    = (KK > 1) ? $clog2(KK) : 1;
  localparam int TW    = (TSZ > 1) ? $clog2(TSZ) : 1;

  localparam logic [KW-1:0] K_LAST = KW'(KK - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TSZ - 1);
  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-W+2){1'b1}}, {(W-1){1'b0}}};

  if ((SIZE - K) % STRIDE != 0) begin : g_bad_stride
    $error("conv2_tiled_engine: (SIZE-SIZEKer) must be a multiple of STRIDE");
  end
  if (OUT % TILES != 0) begin : g_bad_tiles
    $error("conv2_tiled_engine: OUT must be a multiple of TILES");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_MAC   = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                   state_q;
  logic [TW-1:0]            ti_q;
  logic [TW-1:0]            tj_q;
  logic [KW-1:0]            k_q;
  logic signed [W-1:0]      kern_q [KK];
  logic signed [W-1:0]      bias_q;
  logic                     relu_q;
  logic signed [W-1:0]      win_q  [TILES][TILES][KK];
  logic signed [ACC_W-1:0]  acc_q  [TILES][TILES];
  logic signed [W-1:0]      out_q  [OUT][OUT];
  logic                     busy_q;
  logic                     done_q;

  // Bias is aligned to the accumulator's binary point before the rounding-free shift.
  function automatic logic signed [W-1:0] rescale(
    input logic signed [ACC_W-1:0] acc,
    input logic signed [W-1:0]     b,
    input logic                    relu
  );
    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] res;
    logic signed [W-1:0]   r;
    sum = (ACC_W+1)'(acc) + ((ACC_W+1)'(b) <<< FRAC);
    res = sum >>> FRAC;
    if (res > SAT_MAX) begin
      r = SAT_MAX[W-1:0];
    end else if (res < SAT_MIN) begin
      r = SAT_MIN[W-1:0];
    end else begin
      r = res[W-1:0];
    end
    if (relu && r[W-1]) begin
      r = {W{1'b0}};
    end else begin
      r = r;
    end
    return r;
  endfunction

  // Control FSM, lane datapath and result plane.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ti_q    <= {TW{1'b0}};
      tj_q    <= {TW{1'b0}};
      k_q     <= {KW{1'b0}};
      bias_q  <= {W{1'b0}};
      relu_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < KK; i++) kern_q[i] <= {W{1'b0}};
      for (int s = 0; s < TILES; s++) begin
        for (int w = 0; w < TILES; w++) begin
          acc_q[s][w] <= {ACC_W{1'b0}};
          for (int i = 0; i < KK; i++) win_q[s][w][i] <= {W{1'b0}};
        end
      end
      for (int r = 0; r < OUT; r++) begin
        for (int c = 0; c < OUT; c++) out_q[r][c] <= {W{1'b0}};
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            for (int r = 0; r < K; r++) begin
              for (int c = 0; c < K; c++) kern_q[r*K+c] <= bus.kernel[r][c];
            end
            bias_q  <= bus.bias;
            relu_q  <= bus.relu_en;
            ti_q    <= {TW{1'b0}};
            tj_q    <= {TW{1'b0}};
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_LOAD: begin
          for (int s = 0; s < TILES; s++) begin
            for (int w = 0; w < TILES; w++) begin
              acc_q[s][w] <= {ACC_W{1'b0}};
              for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                  win_q[s][w][r*K+c] <=
                    bus.inpMatrixI[(s*TSZ + int'(ti_q))*STRIDE + r][(w*TSZ + int'(tj_q))*STRIDE + c];
                end
              end
            end
          end
          k_q     <= {KW{1'b0}};
          state_q <= S_MAC;
        end
        S_MAC: begin
          for (int s = 0; s < TILES; s++) begin
            for (int w = 0; w < TILES; w++) begin
              acc_q[s][w] <= acc_q[s][w] + ACC_W'(win_q[s][w][k_q]) * ACC_W'(kern_q[k_q]);
            end
          end
          if (k_q == K_LAST) begin
            state_q <= S_WRITE;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        S_WRITE: begin
          for (int s = 0; s < TILES; s++) begin
            for (int w = 0; w < TILES; w++) begin
              out_q[s*TSZ + int'(ti_q)][w*TSZ + int'(tj_q)] <= rescale(acc_q[s][w], bias_q, relu_q);
            end
          end
          if (tj_q == T_LAST) begin
            tj_q <= {TW{1'b0}};
            if (ti_q == T_LAST) begin
              ti_q    <= {TW{1'b0}};
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              ti_q    <= ti_q + TW'(1);
              state_q <= S_LOAD;
            end
          end else begin
            tj_q    <= tj_q + TW'(1);
            state_q <= S_LOAD;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.convIxKernelOut = out_q;
endmodule

// File: tb/tb_conv2_tiled_engine.sv
// Directed bench for conv2_tiled_engine: a default 8x8/stride-1 instance and a
// 9x9/stride-2 instance, checked against hand-computed planes and latencies.
module tb_conv2_tiled_engine;
  localparam int W  = 16;
  localparam int K  = 3;
  localparam int SA = 8;
  localparam int OA = 6;
  localparam int SB = 9;
  localparam int OB = 4;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  conv2_tiled_engine_if #(.SIZE(SA), .SIZEKer(K), .WIDTH_BIT(W), .OUT(OA)) a_if ();
  conv2_tiled_engine_if #(.SIZE(SB), .SIZEKer(K), .WIDTH_BIT(W), .OUT(OB)) b_if ();

  conv2_tiled_engine #(.SIZE(SA), .SIZEKer(K), .STRIDE(1), .TILES(2), .WIDTH_BIT(W), .FRAC(0))
    dut_a (.clock(clock), .reset(reset), .bus(a_if));
  conv2_tiled_engine #(.SIZE(SB), .SIZEKer(K), .STRIDE(2), .TILES(2), .WIDTH_BIT(W), .FRAC(0))
    dut_b (.clock(clock), .reset(reset), .bus(b_if));

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic img_a(input bit ramp, input int v);
    for (int r = 0; r < SA; r++)
      for (int c = 0; c < SA; c++)
        a_if.inpMatrixI[r][c] = ramp ? 16'(8*r + c) : 16'(v);
  endtask

  task automatic kern_a(input bit centre_only, input int v);
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        a_if.kernel[r][c] = centre_only ? ((r == 1 && c == 1) ? 16'sd1 : 16'sd0) : 16'(v);
  endtask

  task automatic plane_a(input string tag, input int v);
    for (int r = 0; r < OA; r++)
      for (int c = 0; c < OA; c++)
        chk($sformatf("%s[%0d][%0d]", tag, r, c), a_if.convIxKernelOut[r][c], v);
  endtask

  task automatic run_a(input string tag, input bit pulse_busy, input bit start_on_done);
    int n;
    int busy_low;
    a_if.start = 1'b1;
    @(posedge clock); #1;
    a_if.start = 1'b0;
    n = 0;
    busy_low = 0;
    while (a_if.done !== 1'b1 && n < 300) begin
      if (a_if.busy !== 1'b1) busy_low++;
      a_if.start = (pulse_busy && (n == 20 || n == 50)) ? 1'b1 : 1'b0;
      @(posedge clock); #1;
      n++;
    end
    a_if.start = 1'b0;
    chk({tag, "_latency"}, n, 99);
    chk({tag, "_busy_span"}, busy_low, 0);
    chk({tag, "_busy_at_done"}, a_if.busy, 0);
    a_if.start = start_on_done;
    @(posedge clock); #1;
    a_if.start = 1'b0;
    chk({tag, "_done_pulse"}, a_if.done, 0);
    chk({tag, "_idle_after"}, a_if.busy, 0);
  endtask

  task automatic run_b(input string tag);
    int n;
    b_if.start = 1'b1;
    @(posedge clock); #1;
    b_if.start = 1'b0;
    chk({tag, "_busy_rise"}, b_if.busy, 1);
    n = 0;
    while (b_if.done !== 1'b1 && n < 300) begin
      @(posedge clock); #1;
      n++;
    end
    chk({tag, "_latency"}, n, 44);
    @(posedge clock); #1;
    chk({tag, "_done_pulse"}, b_if.done, 0);
  endtask

  initial begin
    reset        = 1'b1;
    a_if.start   = 1'b0;
    a_if.relu_en = 1'b0;
    a_if.bias    = 16'sd0;
    b_if.start   = 1'b0;
    b_if.relu_en = 1'b0;
    b_if.bias    = 16'sd0;
    img_a(1'b0, 0);
    kern_a(1'b0, 0);
    for (int r = 0; r < SB; r++)
      for (int c = 0; c < SB; c++)
        b_if.inpMatrixI[r][c] = 16'(16*r + c);
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        b_if.kernel[r][c] = (r == 0 && c == 0) ? 16'sd1 : 16'sd0;

    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", a_if.busy, 0);
    chk("rst_done", a_if.done, 0);
    chk("rst_out00", a_if.convIxKernelOut[0][0], 0);
    chk("rst_out55", a_if.convIxKernelOut[5][5], 0);
    chk("rst_b_out33", b_if.convIxKernelOut[3][3], 0);
    reset = 1'b0;

    // All ones: every window sums to 9; a start during the done cycle is ignored.
    img_a(1'b0, 1);
    kern_a(1'b0, 1);
    run_a("ones", 1'b0, 1'b1);
    plane_a("ones", 9);

    // Centre tap picks img[r+1][c+1].
    img_a(1'b1, 0);
    kern_a(1'b1, 0);
    run_a("ramp", 1'b0, 1'b0);
    for (int r = 0; r < OA; r++)
      for (int c = 0; c < OA; c++)
        chk($sformatf("ramp[%0d][%0d]", r, c), a_if.convIxKernelOut[r][c], 8*(r+1) + (c+1));
    chk("ramp_corner", a_if.convIxKernelOut[5][5], 54);

    // Negative sum with bias, then the same with ReLU.
    img_a(1'b0, 1);
    kern_a(1'b0, -1);
    a_if.bias = 16'sd2;
    run_a("neg", 1'b0, 1'b0);
    plane_a("neg", -7);
    a_if.relu_en = 1'b1;
    run_a("relu", 1'b0, 1'b0);
    plane_a("relu", 0);
    a_if.relu_en = 1'b0;
    a_if.bias    = 16'sd0;

    // Saturation at both rails.
    img_a(1'b0, 32767);
    kern_a(1'b0, 32767);
    run_a("satpos", 1'b0, 1'b0);
    plane_a("satpos", 32767);
    kern_a(1'b0, -32768);
    run_a("satneg", 1'b0, 1'b0);
    plane_a("satneg", -32768);

    // Stride-2 instance: top-left tap picks img[2i][2j] = 32i + 2j.
    run_b("stride");
    for (int i = 0; i < OB; i++)
      for (int j = 0; j < OB; j++)
        chk($sformatf("stride[%0d][%0d]", i, j), b_if.convIxKernelOut[i][j], 32*i + 2*j);

    // Asynchronous reset in the middle of the MAC phase.
    img_a(1'b0, 1);
    kern_a(1'b0, 1);
    a_if.start = 1'b1;
    @(posedge clock); #1;
    a_if.start = 1'b0;
    repeat (5) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_busy", a_if.busy, 0);
    chk("midrst_done", a_if.done, 0);
    plane_a("midrst", 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Start pulses while busy are ignored; the run finishes on schedule.
    run_a("rerun", 1'b1, 1'b0);
    plane_a("rerun", 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
